tile_fprop_sequencer: RTL
=========================

Name: tile_fprop_sequencer

Overview:
Controller that sequences one forward-propagation pass of the neural tile datapath: a layer-0 accumulate over all image pixels, a wait for the hidden activations, then a layer-1 accumulate over all hidden neurons. It generates weight-memory row reads, tracks outstanding reads, and converts returned read data into neuron clear/enable strobes and data indices. It sits between the host start/done handshake, the weight memory and the neuron/sigmoid arrays.

Parameters:
IMG_SZ, 784, layer-0 input count (weight rows 0..IMG_SZ-1)
NUM_NEURONS, 128, hidden count (weight rows IMG_SZ..IMG_SZ+NUM_NEURONS-1)
ACT_LAT, 2, sigmoid pipeline latency in cycles, waited before results are consumed
MAX_OUT, 4, maximum outstanding weight reads

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a pass; accepted only in IDLE
abort  in  1  cancel the current pass
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a pass completes
mem_req  out  1  weight row read request
mem_addr  out  $clog2(IMG_SZ+NUM_NEURONS)  weight row address
mem_ready  in  1  memory accepts request this cycle
mem_rvalid  in  1  weight row returned; responses are in order
clear  out  1  zero all neuron accumulators
en0  out  1  layer-0 accumulate enable
en1  out  1  layer-1 accumulate enable
idx0  out  $clog2(IMG_SZ)  image index for en0
idx1  out  $clog2(NUM_NEURONS)  hidden index for en1

Behaviour:
- Reset: state IDLE; all counters 0; busy, done, mem_req, clear, en0, en1 = 0; mem_addr, idx0, idx1 = 0.
- Issued request = mem_req && mem_ready. Outstanding count: +1 per issued request, -1 per mem_rvalid; both in one cycle leave it unchanged. mem_req is low when outstanding == MAX_OUT, unless a mem_rvalid arrives in the same cycle.
- mem_rvalid when outstanding == 0 is ignored. No en0 or en1 is produced for it.
- States and transitions:
  - IDLE: on start, clear = 1 for one cycle (combinational), then go to L0. start while busy is ignored.
  - L0: issue addresses 0..IMG_SZ-1 in order, one per accepted cycle. Each mem_rvalid produces en0 = 1 in the same cycle, with idx0 = count of layer-0 responses already received. When IMG_SZ responses have been received, go to ACT0.
  - ACT0: wait ACT_LAT cycles, then go to L1.
  - L1: issue addresses IMG_SZ..IMG_SZ+NUM_NEURONS-1. Each mem_rvalid produces en1 with idx1 = layer-1 response count. When NUM_NEURONS responses have been received, go to ACT1.
  - ACT1: wait ACT_LAT cycles, then go to DONE.
  - DONE: done = 1 for one cycle, then go to IDLE.
- Layer-1 requests are not issued before L1 is entered: layer-0 weights and layer-1 weights never share an outstanding window.
- mem_addr holds its value while mem_req && !mem_ready. mem_req stays high until the request is accepted.
- abort in L0, L1, ACT0 or ACT1: go to FLUSH. Abort in IDLE or DONE is ignored; abort in the DONE cycle does not suppress done.
- FLUSH: mem_req = 0; en0 and en1 forced to 0; returned data is discarded. Exit to IDLE when outstanding == 0; if outstanding is already 0, exit on the next cycle. No done pulse. busy stays high.
- abort and start in the same cycle in IDLE: start wins.
- rst_n low mid-pass: everything returns to reset values immediately. No done pulse.
- Pass length with mem_ready = 1 and 1-cycle read latency: done is asserted IMG_SZ+NUM_NEURONS+2*ACT_LAT+3 cycles after start (±1 per state-entry register; the exact number is fixed in RTL and checked by the bench).

Test Plan:
- IMG_SZ=4, NUM_NEURONS=3, ACT_LAT=2, MAX_OUT=4; bench memory: mem_ready = 1, 1-cycle latency. Pulse start -> clear for 1 cycle; mem_addr sequence 0,1,2,3 then 4,5,6; en0 with idx0 0..3, then en1 with idx1 0..2; exactly one done pulse; busy returns low.
- Same parameters, memory latency 6, MAX_OUT=2 -> mem_req never drives a 3rd outstanding request; every index still appears exactly once and in order.
- mem_ready toggling 1,0,0,1,... -> mem_addr stable while stalled; no address is skipped or duplicated.
- abort in L0 with 2 requests outstanding -> no further mem_req; the 2 responses produce no en0; IDLE reached once outstanding is 0; no done; a following start runs a full, correct pass.
- start while busy and stray mem_rvalid in IDLE -> both ignored, no enables produced. rst_n pulsed low mid-L1 -> all outputs 0 immediately, state IDLE.
- start and abort asserted together in IDLE -> pass starts and completes normally with done.

Source files
------------

// File: rtl/tile_fprop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tile_fprop_sequencer
// Purpose  : Sequences one forward-propagation pass of the neural tile:
//            layer-0 accumulate over all image pixels, activation wait,
//            layer-1 accumulate over all hidden neurons, activation wait,
//            done pulse. Issues weight-row reads, tracks outstanding reads
//            and turns returned rows into neuron clear/enable strobes.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start, abort        - host control (start only honoured in IDLE)
//            busy, done          - host status (done is a one-cycle pulse)
//            mem_req/mem_addr    - weight row read request and row address
//            mem_ready           - memory accepts the request this cycle
//            mem_rvalid          - in-order weight row return
//            clear               - zero all neuron accumulators
//            en0/idx0, en1/idx1  - layer-0 / layer-1 accumulate strobe+index
// Revision : 1.0 - initial release
// ============================================================================
module tile_fprop_sequencer #(
  parameter int IMG_SZ      = 784,
  parameter int NUM_NEURONS = 128,
  parameter int ACT_LAT     = 2,
  parameter int MAX_OUT     = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   abort,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   mem_req,
  output logic [$clog2(IMG_SZ+NUM_NEURONS)-1:0]  mem_addr,
  input  logic                                   mem_ready,
  input  logic                                   mem_rvalid,
  output logic                                   clear,
  output logic                                   en0,
  output logic                                   en1,
  output logic [$clog2(IMG_SZ)-1:0]              idx0,
  output logic [$clog2(NUM_NEURONS)-1:0]         idx1
);

  localparam int AW   = $clog2(IMG_SZ + NUM_NEURONS);
  localparam int I0W  = $clog2(IMG_SZ);
  localparam int I1W  = $clog2(NUM_NEURONS);
  localparam int MAXL = (IMG_SZ > NUM_NEURONS) ? IMG_SZ : NUM_NEURONS;
  localparam int CW   = $clog2(MAXL + 1);
  localparam int OW   = $clog2(MAX_OUT + 1);
  localparam int WW   = (ACT_LAT > 1) ? $clog2(ACT_LAT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_L0    = 3'd1,
    S_ACT0  = 3'd2,
    S_L1    = 3'd3,
    S_ACT1  = 3'd4,
    S_DONE  = 3'd5,
    S_FLUSH = 3'd6
  } state_t;

  state_t         state;
  logic [CW-1:0]  issue_cnt;    // requests accepted in the current layer
  logic [CW-1:0]  rsp_cnt;      // responses received in the current layer
  logic [OW-1:0]  outstanding;
  logic [WW-1:0]  wait_cnt;

  logic           in_layer;
  logic           abortable;
  logic           abort_hit;
  logic           rsp_ok;
  logic           room;
  logic           issue;
  logic           last_rsp;
  logic [CW-1:0]  layer_len;

  assign in_layer  = (state == S_L0) || (state == S_L1);
  assign abortable = in_layer || (state == S_ACT0) || (state == S_ACT1);
  assign abort_hit = abort && abortable;
  assign layer_len = (state == S_L1) ? CW'(NUM_NEURONS) : CW'(IMG_SZ);

  // A response with nothing outstanding is a stray and is dropped entirely.
  assign rsp_ok    = mem_rvalid && (outstanding != '0);

  // A response arriving this cycle frees a slot, so a full window may still
  // issue one more request.
  assign room      = (outstanding < OW'(MAX_OUT)) || mem_rvalid;

  // The abort cycle already behaves like FLUSH: nothing new is requested and
  // no enable is produced, so the outstanding count stays exact.
  assign mem_req   = in_layer && (issue_cnt < layer_len) && !abort_hit && room;
  assign issue     = mem_req && mem_ready;
  assign last_rsp  = rsp_ok && (rsp_cnt == layer_len - CW'(1));

  assign mem_addr  = (state == S_L1) ? AW'(IMG_SZ) + AW'(issue_cnt) : AW'(issue_cnt);
  assign en0       = (state == S_L0) && rsp_ok && !abort_hit;
  assign en1       = (state == S_L1) && rsp_ok && !abort_hit;
  assign idx0      = I0W'(rsp_cnt);
  assign idx1      = I1W'(rsp_cnt);
  assign clear     = (state == S_IDLE) && start;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      issue_cnt   <= '0;
      rsp_cnt     <= '0;
      outstanding <= '0;
      wait_cnt    <= '0;
    end else begin
      // Issue and response in the same cycle cancel out.
      case ({issue, rsp_ok})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase

      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_L0;
            issue_cnt <= '0;
            rsp_cnt   <= '0;
            wait_cnt  <= '0;
          end
        end

        S_L0, S_L1: begin
          if (abort_hit) begin
            state <= S_FLUSH;
          end else if (last_rsp) begin
            state     <= (state == S_L0) ? S_ACT0 : S_ACT1;
            issue_cnt <= '0;
            rsp_cnt   <= '0;
            wait_cnt  <= '0;
          end else begin
            if (issue)  issue_cnt <= issue_cnt + CW'(1);
            if (rsp_ok) rsp_cnt   <= rsp_cnt + CW'(1);
          end
        end

        S_ACT0, S_ACT1: begin
          if (abort_hit) begin
            state <= S_FLUSH;
          end else if (wait_cnt == WW'(ACT_LAT - 1)) begin
            state    <= (state == S_ACT0) ? S_L1 : S_DONE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        S_FLUSH: begin
          // Late responses drain here; they only decrement outstanding.
          if (outstanding == '0) begin
            state     <= S_IDLE;
            issue_cnt <= '0;
            rsp_cnt   <= '0;
            wait_cnt  <= '0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
